mem_burst_ctrl: RTL

//  Command front-end upstream of the byte-wide DFF/latch memory array.

---
 rtl/mem_burst_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mem_burst_ctrl.sv
// Purpose: burst read/write command front-end that sequences a level-sensitive byte memory array.
// Latency: write beat is 3 cycles minimum; first read beat is valid 2 cycles after the command handshake.
// Backpressure: cmd_ready only in IDLE; wr_ready only in WR_WAIT; rd_valid/rd_data hold until rd_ready.
//
// Ports:
//   clk, rst                     single clock, synchronous active-high reset
//   cmd_valid/cmd_ready          command stream: cmd_write, cmd_addr (start), cmd_len (beats minus one)
//   wr_valid/wr_ready/wr_data    write-data beat stream
//   rd_valid/rd_ready/rd_data    read-data beat stream
//   mem_addr/mem_wr_en/mem_wdata registered array pins; mem_rdata is combinational from mem_addr
//   busy                         high whenever the sequencer is not idle
module mem_burst_ctrl #(
    parameter int ADDR_BITS = 5,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [ADDR_BITS-1:0] cmd_addr,
    input  logic [ADDR_BITS-1:0] cmd_len,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [DATA_BITS-1:0] rd_data,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_wr_en,
    output logic [DATA_BITS-1:0] mem_wdata,
    input  logic [DATA_BITS-1:0] mem_rdata,
    output logic                 busy
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_WAIT  = 3'd1,
        WR_PULSE = 3'd2,
        WR_HOLD  = 3'd3,
        RD_SETUP = 3'd4,
        RD_OUT   = 3'd5
    } state_t;

    localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);

    state_t                 state_q,     state_d;
    logic [ADDR_BITS-1:0]   cur_addr_q,  cur_addr_d;
    logic [ADDR_BITS-1:0]   count_q,     count_d;
    logic [ADDR_BITS-1:0]   mem_addr_q,  mem_addr_d;
    logic                   mem_wr_en_q, mem_wr_en_d;
    logic [DATA_BITS-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_BITS-1:0]   rd_data_q,   rd_data_d;
    logic                   rd_valid_q,  rd_valid_d;

    // Handshake readies are pure state decodes, so they are glitch-free and
    // never depend on the upstream valid.
    assign cmd_ready = (state_q == IDLE);
    assign wr_ready  = (state_q == WR_WAIT);
    assign busy      = (state_q != IDLE);

    assign mem_addr  = mem_addr_q;
    assign mem_wr_en = mem_wr_en_q;
    assign mem_wdata = mem_wdata_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        count_d     = count_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = rd_valid_q;
        // The enable pin is registered, so it is high on the pin during the
        // cycle after WR_PULSE. That puts one idle edge between the addr/wdata
        // update and the rising enable, and another between the falling enable
        // and the earliest next addr/wdata update.
        mem_wr_en_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    cur_addr_d = cmd_addr;
                    count_d    = cmd_len;
                    if (cmd_write) begin
                        state_d = WR_WAIT;
                    end else begin
                        mem_addr_d = cmd_addr;
                        state_d    = RD_SETUP;
                    end
                end
            end
            WR_WAIT: begin
                if (wr_valid) begin
                    mem_addr_d  = cur_addr_q;
                    mem_wdata_d = wr_data;
                    state_d     = WR_PULSE;
                end
            end
            WR_PULSE: begin
                mem_wr_en_d = 1'b1;
                state_d     = WR_HOLD;
            end
            WR_HOLD: begin
                if (count_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cur_addr_d = cur_addr_q + ADDR_ONE;  // wraps modulo depth
                    count_d    = count_q - ADDR_ONE;
                    state_d    = WR_WAIT;
                end
            end
            RD_SETUP: begin
                // mem_addr has been stable for this whole cycle; sample the array.
                rd_data_d  = mem_rdata;
                rd_valid_d = 1'b1;
                state_d    = RD_OUT;
            end
            RD_OUT: begin
                if (rd_ready) begin
                    rd_valid_d = 1'b0;
                    if (count_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cur_addr_d = cur_addr_q + ADDR_ONE;
                        mem_addr_d = cur_addr_q + ADDR_ONE;
                        count_d    = count_q - ADDR_ONE;
                        state_d    = RD_SETUP;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            count_q     <= '0;
            mem_addr_q  <= '0;
            mem_wr_en_q <= 1'b0;
            mem_wdata_q <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            count_q     <= count_d;
            mem_addr_q  <= mem_addr_d;
            mem_wr_en_q <= mem_wr_en_d;
            mem_wdata_q <= mem_wdata_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

endmodule
